// File: rtl/image_mode_ctrl_pkg.sv
// Shared mode codes, field widths and FSM state type for the image configuration
// sequencer; the mode codes are also used by the pipeline output mux.
package image_mode_ctrl_pkg;

    localparam int unsigned DISP_W   = 3;
    localparam int unsigned PROC_W   = 3;
    localparam int unsigned THR_W    = 7;
    localparam int unsigned TMO_W    = 24;
    localparam int unsigned SETTLE_W = 8;

    typedef enum logic [DISP_W-1:0] {
        DISP_RGB   = 3'd0,
        DISP_RGB_R = 3'd1,
        DISP_RGB_G = 3'd2,
        DISP_RGB_B = 3'd3,
        DISP_YUV_Y = 3'd4
    } disp_mode_e;

    typedef enum logic [PROC_W-1:0] {
        PROC_NOP      = 3'd0,
        PROC_SOBEL    = 3'd1,
        PROC_MEAN     = 3'd2,
        PROC_MEDIUM   = 3'd3,
        PROC_GAUSSIAN = 3'd4,
        PROC_EROSION  = 3'd5,
        PROC_DILATION = 3'd6
    } proc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SETTLE
    } state_e;

    // Saturating threshold step; simultaneous up and down cancel out.
    function automatic logic [THR_W-1:0] thr_next(
        input logic [THR_W-1:0] cur,
        input logic             up,
        input logic             dn,
        input logic [THR_W-1:0] step
    );
        logic [THR_W:0] sum;
        sum      = {1'b0, cur} + {1'b0, step};
        thr_next = cur;
        if (up && !dn) begin
            thr_next = sum[THR_W] ? '1 : sum[THR_W-1:0];
        end else if (dn && !up) begin
            thr_next = (cur < step) ? '0 : cur - step;
        end
    endfunction

endpackage

// File: rtl/image_mode_ctrl_if.sv
// Frame/key inputs and committed configuration outputs of the mode sequencer.
interface image_mode_ctrl_if;
    import image_mode_ctrl_pkg::*;

    logic              pre_frame_vsync;
    logic              key_disp;
    logic              key_proc;
    logic              key_thr_up;
    logic              key_thr_dn;
    logic [DISP_W-1:0] image_disp;
    logic [PROC_W-1:0] image_proc;
    logic [THR_W-1:0]  sobel_threshold;
    logic              disp_mute;
    logic              cfg_pending;
    logic              cfg_commit;

    modport master (
        output pre_frame_vsync, key_disp, key_proc, key_thr_up, key_thr_dn,
        input  image_disp, image_proc, sobel_threshold, disp_mute, cfg_pending, cfg_commit
    );

    modport slave (
        input  pre_frame_vsync, key_disp, key_proc, key_thr_up, key_thr_dn,
        output image_disp, image_proc, sobel_threshold, disp_mute, cfg_pending, cfg_commit
    );

endinterface

// File: rtl/image_mode_ctrl_frame_edge_det.sv
// Registers frame-valid and flags its rising/falling edges for one cycle.
module frame_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync_i,
    output logic rise_o,
    output logic fall_o
);

    logic vsync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign rise_o = ~vsync_q & vsync_i;
    assign fall_o = vsync_q & ~vsync_i;

endmodule

// File: rtl/image_mode_ctrl.sv
// Holds key requests as pending config, commits them atomically at a frame
// boundary (or on timeout) and mutes the display while the pipelines refill.
module image_mode_ctrl
    import image_mode_ctrl_pkg::*;
#(
    parameter logic [THR_W-1:0] THR_INIT      = 7'd40,
    parameter int unsigned      THR_STEP      = 4,
    parameter int unsigned      SETTLE_FRAMES = 1,
    parameter int unsigned      TIMEOUT_CYC   = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    image_mode_ctrl_if.slave   bus
);

    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);
    localparam logic [THR_W-1:0]    STEP        = THR_W'(THR_STEP);
    localparam logic                USE_SETTLE  = (SETTLE_FRAMES != 0);

    state_e              state_q, state_d;
    logic [DISP_W-1:0]   disp_q, disp_d, pend_disp_q, pend_disp_d;
    logic [PROC_W-1:0]   proc_q, proc_d, pend_proc_q, pend_proc_d;
    logic [THR_W-1:0]    thr_q, thr_d, pend_thr_q, pend_thr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                mute_q, mute_d;
    logic                commit_q, commit_d;
    logic                pending_q;
    logic                rise, fall, any_key;

    frame_edge_det u_edge (
        .clk_i   (clk),
        .rst_i   (rst),
        .vsync_i (bus.pre_frame_vsync),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign any_key = bus.key_disp | bus.key_proc | bus.key_thr_up | bus.key_thr_dn;

    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        proc_d      = proc_q;
        thr_d       = thr_q;
        tmo_d       = tmo_q;
        settle_d    = settle_q;
        mute_d      = mute_q;
        commit_d    = 1'b0;

        pend_disp_d = pend_disp_q;
        pend_proc_d = pend_proc_q;
        if (bus.key_disp) begin
            pend_disp_d = (pend_disp_q == DISP_YUV_Y) ? DISP_RGB : pend_disp_q + 3'd1;
        end
        if (bus.key_proc) begin
            pend_proc_d = (pend_proc_q == PROC_DILATION) ? PROC_NOP : pend_proc_q + 3'd1;
        end
        pend_thr_d = thr_next(pend_thr_q, bus.key_thr_up, bus.key_thr_dn, STEP);

        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (any_key) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                // Commit takes the registered pending values; a key in this cycle lands in the next batch.
                if (fall || tmo_q == TMO_LAST) begin
                    disp_d   = pend_disp_q;
                    proc_d   = pend_proc_q;
                    thr_d    = pend_thr_q;
                    commit_d = 1'b1;
                    tmo_d    = '0;
                    settle_d = '0;
                    mute_d   = USE_SETTLE;
                    if (any_key)         state_d = ST_PENDING;
                    else if (USE_SETTLE) state_d = ST_SETTLE;
                    else                 state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_SETTLE: begin
                if (any_key) begin
                    state_d = ST_PENDING;
                    tmo_d   = '0;
                end else if (rise) begin
                    tmo_d = '0;
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_IDLE;
                        mute_d  = 1'b0;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    mute_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            disp_q      <= DISP_RGB;
            proc_q      <= PROC_NOP;
            thr_q       <= THR_INIT;
            pend_disp_q <= DISP_RGB;
            pend_proc_q <= PROC_NOP;
            pend_thr_q  <= THR_INIT;
            tmo_q       <= '0;
            settle_q    <= '0;
            mute_q      <= 1'b0;
            commit_q    <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            proc_q      <= proc_d;
            thr_q       <= thr_d;
            pend_disp_q <= pend_disp_d;
            pend_proc_q <= pend_proc_d;
            pend_thr_q  <= pend_thr_d;
            tmo_q       <= tmo_d;
            settle_q    <= settle_d;
            mute_q      <= mute_d;
            commit_q    <= commit_d;
            pending_q   <= (state_d == ST_PENDING);
        end
    end

    assign bus.image_disp      = disp_q;
    assign bus.image_proc      = proc_q;
    assign bus.sobel_threshold = thr_q;
    assign bus.disp_mute       = mute_q;
    assign bus.cfg_pending     = pending_q;
    assign bus.cfg_commit      = commit_q;

endmodule

// File: tb/tb_image_mode_ctrl.sv
// Self-checking bench for image_mode_ctrl: directed scenarios plus randomized
// keys/frames compared against a cycle-level behavioural model.
module tb_image_mode_ctrl;

    localparam int TMO    = 50;
    localparam int SETTLE = 1;
    localparam int STEP   = 4;
    localparam int THR0   = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    image_mode_ctrl_if bus ();

    image_mode_ctrl #(
        .THR_INIT      (7'd40),
        .THR_STEP      (STEP),
        .SETTLE_FRAMES (SETTLE),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit vs_auto   = 1'b1;
    int act_len   = 100;
    int blank_len = 20;
    int phase     = 0;

    // Behavioural model: committed/pending values and flags for the three phases.
    int m_disp, m_proc, m_thr, p_disp, p_proc, p_thr;
    int m_quiet, m_rises;
    bit m_waiting, m_settling, m_muted, m_commit, m_prev_vs;

    task automatic model_reset();
        m_disp = 0; m_proc = 0; m_thr = THR0;
        p_disp = 0; p_proc = 0; p_thr = THR0;
        m_quiet = 0; m_rises = 0;
        m_waiting = 0; m_settling = 0; m_muted = 0; m_commit = 0; m_prev_vs = 0;
    endtask

    task automatic model_edge(input bit r, input bit vs, input bit kd, input bit kp,
                              input bit ku, input bit kdn);
        bit fall, rise, any, fire;
        if (r) begin
            model_reset();
            return;
        end
        fall = m_prev_vs && !vs;
        rise = !m_prev_vs && vs;
        m_prev_vs = vs;
        any  = kd | kp | ku | kdn;
        fire = m_waiting && (fall || m_quiet == TMO - 1);
        m_commit = fire;
        if (fire) begin
            m_disp = p_disp; m_proc = p_proc; m_thr = p_thr;
            m_muted    = (SETTLE > 0);
            m_waiting  = any;
            m_settling = !any && (SETTLE > 0);
            m_quiet = 0; m_rises = 0;
        end else if (m_waiting) begin
            m_quiet = m_quiet + 1;
        end else if (m_settling) begin
            if (any) begin
                m_settling = 0; m_waiting = 1; m_quiet = 0;
            end else if (rise) begin
                m_rises = m_rises + 1;
                m_quiet = 0;
                if (m_rises == SETTLE) begin
                    m_settling = 0; m_muted = 0;
                end
            end else if (m_quiet == TMO - 1) begin
                m_settling = 0; m_muted = 0;
            end else begin
                m_quiet = m_quiet + 1;
            end
        end else if (any) begin
            m_waiting = 1; m_quiet = 0;
        end
        p_disp = (p_disp + int'(kd)) % 5;
        p_proc = (p_proc + int'(kp)) % 7;
        if (ku && !kdn)      p_thr = (p_thr + STEP > 127) ? 127 : p_thr + STEP;
        else if (kdn && !ku) p_thr = (p_thr < STEP) ? 0 : p_thr - STEP;
    endtask

    function automatic logic [15:0] obs();
        return {bus.image_disp, bus.image_proc, bus.sobel_threshold,
                bus.disp_mute, bus.cfg_pending, bus.cfg_commit};
    endfunction

    function automatic logic [15:0] expv();
        return {3'(m_disp), 3'(m_proc), 7'(m_thr), m_muted, m_waiting, m_commit};
    endfunction

    task automatic step(input bit r, input bit kd, input bit kp, input bit ku, input bit kdn);
        bit vs;
        vs = vs_auto ? (phase < act_len) : 1'b0;
        rst = r;
        bus.pre_frame_vsync = vs;
        bus.key_disp = kd; bus.key_proc = kp; bus.key_thr_up = ku; bus.key_thr_dn = kdn;
        @(posedge clk);
        model_edge(r, vs, kd, kp, ku, kdn);
        phase = (phase + 1) % (act_len + blank_len);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== {3'd0, 3'd0, 7'd40, 3'b000})
            $display("FAIL reset_values got=%h exp=%h", obs(), {3'd0, 3'd0, 7'd40, 3'b000});
        else n_pass++;
        for (int i = 0; i < 240; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL idle_frames cyc=%0d got=%h exp=%h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if ({bus.sobel_threshold, bus.disp_mute} !== {7'd40, 1'b0})
            $display("FAIL idle_hold got thr=%0d mute=%b exp thr=40 mute=0", bus.sobel_threshold, bus.disp_mute);
        else n_pass++;
    endtask

    task automatic test_commit_at_fall();
        while (phase != 70) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        n_checks++;
        if ({bus.cfg_pending, bus.image_proc} !== {1'b1, 3'd0})
            $display("FAIL pending_mid_frame got pend=%b proc=%0d exp pend=1 proc=0", bus.cfg_pending, bus.image_proc);
        else n_pass++;
        for (int i = 0; i < 28; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL hold_until_fall cyc=%0d got=%h exp=%h", i, obs(), expv());
            else n_pass++;
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.image_proc, bus.cfg_commit, bus.disp_mute, bus.cfg_pending} !== {3'd2, 3'b110})
            $display("FAIL commit_at_fall got proc=%0d commit=%b mute=%b pend=%b exp 2/1/1/0",
                     bus.image_proc, bus.cfg_commit, bus.disp_mute, bus.cfg_pending);
        else n_pass++;
        for (int i = 0; i < 19; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL mute_blank cyc=%0d got=%h exp=%h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (bus.disp_mute !== 1'b1) $display("FAIL mute_before_rise got=%b exp=1", bus.disp_mute);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.disp_mute, bus.image_proc} !== {1'b0, 3'd2})
            $display("FAIL unmute_after_rise got mute=%b proc=%0d exp mute=0 proc=2", bus.disp_mute, bus.image_proc);
        else n_pass++;
    endtask

    task automatic run_compare(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
        run_compare(150, "thr_up_run");
        n_checks++;
        if (bus.sobel_threshold !== 7'd127) $display("FAIL thr_saturate_hi got=%0d exp=127", bus.sobel_threshold);
        else n_pass++;
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1);
        run_compare(150, "thr_dn_run");
        n_checks++;
        if (bus.sobel_threshold !== 7'd0) $display("FAIL thr_saturate_lo got=%0d exp=0", bus.sobel_threshold);
        else n_pass++;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 1);
        run_compare(150, "thr_cancel_run");
        n_checks++;
        if (bus.sobel_threshold !== 7'd12) $display("FAIL thr_up_dn_cancel got=%0d exp=12", bus.sobel_threshold);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit saw_commit;
        saw_commit = 1'b0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
        n_checks++;
        if (bus.cfg_pending !== 1'b1) $display("FAIL wrap_pending got=%b exp=1", bus.cfg_pending);
        else n_pass++;
        for (int i = 0; i < 150; i++) begin
            step(0, 0, 0, 0, 0);
            saw_commit |= bus.cfg_commit;
            n_checks++;
            if (obs() !== expv()) $display("FAIL wrap_run cyc=%0d got=%h exp=%h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if ({bus.image_disp, bus.image_proc, saw_commit} !== {3'd0, 3'd0, 1'b1})
            $display("FAIL wrap_zero got disp=%0d proc=%0d commit_seen=%b exp 0/0/1",
                     bus.image_disp, bus.image_proc, saw_commit);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int exp_disp, old_disp;
        vs_auto = 1'b0;
        run_compare(150, "timeout_drain");
        n_checks++;
        if ({bus.cfg_pending, bus.disp_mute} !== 2'b00)
            $display("FAIL timeout_idle got pend=%b mute=%b exp 0/0", bus.cfg_pending, bus.disp_mute);
        else n_pass++;
        old_disp = m_disp;
        exp_disp = (m_disp + 1) % 5;
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (i < 50) begin
                if ({bus.cfg_commit, bus.image_disp} !== {1'b0, 3'(old_disp)})
                    $display("FAIL timeout_early cyc=%0d got commit=%b disp=%0d exp 0/%0d",
                             i, bus.cfg_commit, bus.image_disp, old_disp);
                else n_pass++;
            end else begin
                if ({bus.cfg_commit, bus.disp_mute, bus.image_disp} !== {2'b11, 3'(exp_disp)})
                    $display("FAIL timeout_commit_50 got commit=%b mute=%b disp=%0d exp 1/1/%0d",
                             bus.cfg_commit, bus.disp_mute, bus.image_disp, exp_disp);
                else n_pass++;
            end
        end
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (bus.disp_mute !== ((i < 50) ? 1'b1 : 1'b0))
                $display("FAIL timeout_unmute cyc=%0d got=%b exp=%b", i, bus.disp_mute, (i < 50));
            else n_pass++;
        end
    endtask

    task automatic test_key_at_fall();
        vs_auto = 1'b1; act_len = 30; blank_len = 10; phase = 0;
        step(1, 0, 0, 0, 0);
        while (phase != 20) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        run_compare(9, "kaf_pre");
        step(0, 1, 0, 0, 0);
        n_checks++;
        if ({bus.image_proc, bus.image_disp, bus.cfg_commit, bus.cfg_pending, bus.disp_mute} !== {3'd1, 3'd0, 3'b111})
            $display("FAIL key_at_fall_commit got proc=%0d disp=%0d commit=%b pend=%b mute=%b exp 1/0/1/1/1",
                     bus.image_proc, bus.image_disp, bus.cfg_commit, bus.cfg_pending, bus.disp_mute);
        else n_pass++;
        run_compare(39, "kaf_wait");
        step(0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.image_disp, bus.cfg_commit, bus.cfg_pending, bus.disp_mute} !== {3'd1, 3'b101})
            $display("FAIL key_at_fall_next got disp=%0d commit=%b pend=%b mute=%b exp 1/1/0/1",
                     bus.image_disp, bus.cfg_commit, bus.cfg_pending, bus.disp_mute);
        else n_pass++;
        run_compare(20, "kaf_settle");
        step(0, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== {3'd0, 3'd0, 7'd40, 3'b000})
            $display("FAIL reset_discard got=%h exp=%h", obs(), {3'd0, 3'd0, 7'd40, 3'b000});
        else n_pass++;
        run_compare(60, "reset_after");
        n_checks++;
        if ({bus.image_disp, bus.image_proc, bus.sobel_threshold} !== {3'd0, 3'd0, 7'd40})
            $display("FAIL reset_no_commit got disp=%0d proc=%0d thr=%0d exp 0/0/40",
                     bus.image_disp, bus.image_proc, bus.sobel_threshold);
        else n_pass++;
    endtask

    task automatic test_random();
        bit r, kd, kp, ku, kdn;
        for (int c = 0; c < 8; c++) begin
            act_len   = $urandom_range(40, 90);
            blank_len = $urandom_range(8, 20);
            phase     = 0;
            for (int i = 0; i < 400; i++) begin
                r   = ($urandom_range(0, 499) == 0);
                kd  = ($urandom_range(0, 15) == 0);
                kp  = ($urandom_range(0, 15) == 0);
                ku  = ($urandom_range(0, 11) == 0);
                kdn = ($urandom_range(0, 11) == 0);
                step(r, kd, kp, ku, kdn);
                n_checks++;
                if (obs() !== expv()) $display("FAIL random c=%0d cyc=%0d got=%h exp=%h", c, i, obs(), expv());
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.pre_frame_vsync = 1'b0;
        bus.key_disp = 1'b0; bus.key_proc = 1'b0; bus.key_thr_up = 1'b0; bus.key_thr_dn = 1'b0;
        model_reset();
        test_reset();
        test_commit_at_fall();
        test_threshold();
        test_wrap();
        test_timeout();
        test_key_at_fall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
